diff_reader: RTL and testbench

Frame scanner on the read side of the spectral-difference bin store. On each frame tick it walks every bin address, reads the 8-bit difference value, and applies gain with saturation and per-bin peak-hold with linear decay. It then streams one 8-bit level per bin, in bin order, over a valid/ready handshake to the LED-strip pixel driver.

---
 rtl/diff_reader.sv | 103 ++++++++++
 tb/tb_diff_reader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/diff_reader.sv
// Frame scanner: reads each bin, applies saturating gain and decaying peak-hold, streams one level per bin.
// Each bin takes one READ cycle plus one or more SEND cycles; pix_valid holds with data and addr stable until pix_ready.
module diff_reader #(
    parameter int NUM_BINS   = 40,
    parameter int GAIN_SHIFT = 0,
    parameter int DECAY      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] addr,
    input  logic [7:0] bin_in,
    output logic [7:0] pix_data,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic       busy,
    output logic       frame_done
);
    localparam int         IW   = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
    localparam logic [7:0] LAST = 8'(NUM_BINS - 1);
    localparam logic [7:0] DEC  = 8'(DECAY);

    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    pix_q, pix_d;
    logic [7:0]    peak_q [NUM_BINS];
    logic [7:0]    peak_d [NUM_BINS];
    logic [IW-1:0] bidx;
    logic [15:0]   shifted;
    logic [7:0]    lvl, cur_peak, dec, nxt;

    assign bidx = idx_q[IW-1:0];

    // Gain is widened to 16 bits so the saturation test sees every shifted-out bit.
    always_comb begin
        shifted  = 16'(bin_in) << GAIN_SHIFT;
        lvl      = (shifted > 16'd255) ? 8'hFF : shifted[7:0];
        cur_peak = peak_q[bidx];
        dec      = (cur_peak > DEC) ? (cur_peak - DEC) : 8'd0;
        nxt      = (lvl > dec) ? lvl : dec;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pix_d   = pix_q;
        peak_d  = peak_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    idx_d   = 8'd0;
                end
            end
            READ: begin
                pix_d        = nxt;
                peak_d[bidx] = nxt;
                state_d      = SEND;
            end
            SEND: begin
                if (pix_ready) begin
                    if (idx_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = 8'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= 8'd0;
            pix_q   <= 8'd0;
            for (int i = 0; i < NUM_BINS; i++) begin
                peak_q[i] <= 8'd0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pix_q   <= pix_d;
            for (int i = 0; i < NUM_BINS; i++) begin
                peak_q[i] <= peak_d[i];
            end
        end
    end

    assign addr       = idx_q;
    assign pix_data   = pix_q;
    assign pix_valid  = (state_q == SEND);
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
endmodule

// File: tb/tb_diff_reader.sv
// Directed bench for diff_reader: reset, basic frame, decay/peak, gain saturation, backpressure, start while busy.
module tb_diff_reader;
    logic       clk;
    logic       rst;
    logic       start, start_g;
    logic [7:0] addr, addr_g, bin_in, bin_in_g, pix_data, pix_data_g;
    logic       pix_valid, pix_valid_g, pix_ready, pix_ready_g;
    logic       busy, busy_g, frame_done, frame_done_g;

    logic [7:0] mem   [256];
    logic [7:0] mem_g [256];
    logic [7:0] pk    [40];
    int         got   [40];
    int         got_g [8];
    int         pass_cnt = 0;
    int         chk_cnt  = 0;

    typedef struct {
        logic [7:0] in3;
        logic [7:0] in7;
        logic [7:0] exp3;
        logic [7:0] exp7;
    } dvec_t;

    typedef struct {
        logic [7:0] in;
        logic [7:0] exp;
    } gvec_t;

    assign bin_in   = mem[addr];
    assign bin_in_g = mem_g[addr_g];

    diff_reader #(.NUM_BINS(40), .GAIN_SHIFT(0), .DECAY(4)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .bin_in(bin_in),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .busy(busy), .frame_done(frame_done)
    );

    diff_reader #(.NUM_BINS(8), .GAIN_SHIFT(2), .DECAY(4)) dut_g (
        .clk(clk), .rst(rst), .start(start_g), .addr(addr_g), .bin_in(bin_in_g),
        .pix_data(pix_data_g), .pix_valid(pix_valid_g), .pix_ready(pix_ready_g),
        .busy(busy_g), .frame_done(frame_done_g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic logic [7:0] model_lvl(input logic [7:0] in, input logic [7:0] p);
        int s;
        int l;
        int d;
        s = int'(in);
        l = (s > 255) ? 255 : s;
        d = (p > 8'd4) ? int'(p) - 4 : 0;
        return 8'((l > d) ? l : d);
    endfunction

    // Compares every bin against the peak-hold model and advances the model.
    task automatic check_frame(input string nm);
        logic [7:0] e;
        for (int i = 0; i < 40; i++) begin
            e = model_lvl(mem[i], pk[i]);
            chk($sformatf("%s bin%0d", nm, i), got[i], int'(e));
            pk[i] = e;
        end
    endtask

    task automatic run_frame(input int stall_bin, input int stall_n, input bit poke,
                             output int done_cyc, output int hs);
        int         c;
        int         left;
        bit         held;
        logic [7:0] sd;
        logic [7:0] sa;
        left = stall_n; hs = 0; done_cyc = -1; held = 1'b0; sd = 8'd0; sa = 8'd0;
        for (int i = 0; i < 40; i++) got[i] = -1;
        pix_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); c = 1;
        while (c < 400 && done_cyc < 0) begin
            if (frame_done) begin
                done_cyc = c;
                start    = poke;
            end else begin
                start = poke && (c == 1 || c == 2 || c == 6);
                if (left > 0 && (held || (pix_valid && int'(addr) == stall_bin))) begin
                    if (!held) begin
                        sd = pix_data; sa = addr; held = 1'b1;
                    end else begin
                        chk("stall valid", int'(pix_valid), 1);
                        chk("stall data", int'(pix_data), int'(sd));
                        chk("stall addr", int'(addr), int'(sa));
                    end
                    pix_ready = 1'b0;
                    left--;
                end else begin
                    pix_ready = 1'b1;
                    if (pix_valid) begin
                        if (hs < 40) got[hs] = int'(pix_data);
                        if (int'(addr) != hs) chk("bin order", int'(addr), hs);
                        hs++;
                    end
                end
            end
            @(negedge clk); c++;
        end
        start = 1'b0;
        if (done_cyc < 0) chk("frame_done timeout", 0, 1);
        chk("busy low after frame", int'(busy), 0);
    endtask

    initial begin
        dvec_t dtab [3];
        gvec_t gtab [8];
        int    dc;
        int    hs;
        int    c;
        int    extra;

        dtab[0] = '{in3: 8'd100, in7: 8'd6, exp3: 8'd100, exp7: 8'd6};
        dtab[1] = '{in3: 8'd0,   in7: 8'd0, exp3: 8'd96,  exp7: 8'd2};
        dtab[2] = '{in3: 8'd98,  in7: 8'd0, exp3: 8'd98,  exp7: 8'd0};
        gtab[0] = '{in: 8'd63,  exp: 8'd252};
        gtab[1] = '{in: 8'd64,  exp: 8'd255};
        gtab[2] = '{in: 8'd255, exp: 8'd255};
        gtab[3] = '{in: 8'd0,   exp: 8'd0};
        gtab[4] = '{in: 8'd1,   exp: 8'd4};
        gtab[5] = '{in: 8'd10,  exp: 8'd40};
        gtab[6] = '{in: 8'd32,  exp: 8'd128};
        gtab[7] = '{in: 8'd200, exp: 8'd255};

        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'd0; mem_g[i] = 8'd0;
        end
        for (int i = 0; i < 40; i++) pk[i] = 8'd0;
        start = 1'b0; start_g = 1'b0; pix_ready = 1'b1; pix_ready_g = 1'b1;
        rst = 1'b0;
        #1;
        chk("reset addr", int'(addr), 0);
        chk("reset pix_data", int'(pix_data), 0);
        chk("reset pix_valid", int'(pix_valid), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset frame_done", int'(frame_done), 0);
        @(negedge clk); @(negedge clk); rst = 1'b1;
        @(negedge clk);

        // Basic frame: ramp input, peaks start at 0.
        for (int i = 0; i < 40; i++) mem[i] = 8'(i);
        run_frame(-1, 0, 1'b0, dc, hs);
        chk("basic done cycle", dc, 81);
        chk("basic handshakes", hs, 40);
        for (int i = 0; i < 40; i++) chk($sformatf("basic bin%0d", i), got[i], i);
        for (int i = 0; i < 40; i++) pk[i] = 8'(i);

        // Reset mid-SEND at bin 5.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        c = 0;
        while (!(pix_valid && addr == 8'd5) && c < 100) begin
            @(negedge clk); c++;
        end
        chk("reach bin5 send", int'(pix_valid && addr == 8'd5), 1);
        #2 rst = 1'b0;
        #1;
        chk("async rst pix_valid", int'(pix_valid), 0);
        chk("async rst busy", int'(busy), 0);
        chk("async rst addr", int'(addr), 0);
        chk("async rst pix_data", int'(pix_data), 0);
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (frame_done) extra++;
        end
        chk("no frame_done on reset", extra, 0);
        rst = 1'b1;
        for (int i = 0; i < 40; i++) pk[i] = 8'd0;
        @(negedge clk);
        for (int i = 0; i < 40; i++) mem[i] = 8'd10;
        run_frame(-1, 0, 1'b0, dc, hs);
        for (int i = 0; i < 40; i++) chk($sformatf("post-reset bin%0d", i), got[i], 10);
        for (int i = 0; i < 40; i++) pk[i] = 8'd10;

        // Decay / peak-hold / floor across three frames.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 40; i++) mem[i] = 8'd0;
            mem[3] = dtab[f].in3;
            mem[7] = dtab[f].in7;
            run_frame(-1, 0, 1'b0, dc, hs);
            chk($sformatf("decay f%0d bin3", f), got[3], int'(dtab[f].exp3));
            chk($sformatf("decay f%0d bin7", f), got[7], int'(dtab[f].exp7));
            check_frame($sformatf("decay f%0d", f));
        end

        // Backpressure on bin 10 for 7 cycles.
        for (int i = 0; i < 40; i++) mem[i] = 8'(i);
        run_frame(10, 7, 1'b0, dc, hs);
        chk("stall done cycle", dc, 88);
        chk("stall handshakes", hs, 40);
        check_frame("stall");

        // start pulsed in READ, SEND and DONE: all ignored.
        run_frame(-1, 0, 1'b1, dc, hs);
        chk("poke done cycle", dc, 81);
        chk("poke handshakes", hs, 40);
        check_frame("poke");
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (frame_done || busy) extra++;
        end
        chk("no restart after poke", extra, 0);

        // Gain saturation on the GAIN_SHIFT=2 instance.
        for (int i = 0; i < 8; i++) begin
            mem_g[i] = gtab[i].in; got_g[i] = -1;
        end
        @(negedge clk); start_g = 1'b1;
        @(negedge clk); start_g = 1'b0;
        c = 1; dc = -1; hs = 0;
        while (c < 100 && dc < 0) begin
            if (frame_done_g) dc = c;
            else if (pix_valid_g && hs < 8) begin
                got_g[hs] = int'(pix_data_g); hs++;
            end
            @(negedge clk); c++;
        end
        chk("gain done cycle", dc, 17);
        for (int i = 0; i < 8; i++)
            chk($sformatf("gain in=%0d", gtab[i].in), got_g[i], int'(gtab[i].exp));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
